rr_sched_16bit_4x1mux: RTL and testbench

//   Round-robin scheduler sharing one 16-bit 4:1 mux output path among four requesters.

---
 rtl/rr_sched_pkg.sv | 19 +
 rtl/rr_sched_16bit_4x1mux_pick.sv | 28 ++
 rtl/rr_sched_16bit_4x1mux.sv | 132 +++++++++++++
 tb/tb_rr_sched_16bit_4x1mux.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin 4:1 mux scheduler.
package rr_sched_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_sched_16bit_4x1mux_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr and returns the first set req.
// Zero latency; no flow control of its own.
module rr_pick4
    import rr_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    logic [IDX_W-1:0] cand;

    // Walk the search order backwards so the highest-priority hit is written last.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                win_idx = cand;
                win_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_sched_16bit_4x1mux.sv
// Round-robin scheduler driving a 16-bit 4:1 mux into a registered valid/ready slot (ARB_BURST_EN: sticky bursts).
// Latency: req to out_valid 1 cycle; one beat per cycle while out_ready stays high.
// Backpressure: out_valid & !out_ready freezes the slot and suppresses every gnt.
module rr_sched_16bit_4x1mux
    import rr_sched_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [DATA_W-1:0] inp_1,
    input  logic [DATA_W-1:0] inp_2,
    input  logic [DATA_W-1:0] inp_3,
    input  logic [DATA_W-1:0] inp_4,
    output logic [N_REQ-1:0]  gnt,
    output logic              selec_1,
    output logic              selec_2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    sched_state_t      state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [IDX_W-1:0]  rr_idx;
    logic              rr_vld;
    logic [IDX_W-1:0]  win_idx;
    logic              win_vld;
    logic              slot_free;
    logic              accept;
    logic [DATA_W-1:0] sel_data;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_idx (rr_idx),
        .win_vld (rr_vld)
    );

`ifdef ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // Zero means no burst in progress, so the first beat after reset never sticks to ptr=3.
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             burst_hold;

    assign burst_hold = (burst_q != '0) && req[ptr_q];
    assign win_idx    = burst_hold ? ptr_q : rr_idx;
    assign win_vld    = burst_hold | rr_vld;

    always_comb begin
        burst_d = burst_q;
        if (accept) begin
            if ((win_idx == ptr_q) && (burst_q != '0)) begin
                burst_d = burst_q + CNT_W'(1);
            end else begin
                burst_d = CNT_W'(1);
            end
            if (burst_d == CNT_W'(MAX_BURST)) begin
                burst_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic unused_max_burst;

    assign unused_max_burst = (MAX_BURST > 0);
    assign win_idx          = rr_idx;
    assign win_vld          = rr_vld;
`endif

    assign slot_free = (state_q == IDLE) || out_ready;
    assign accept    = slot_free && win_vld;

    always_comb begin
        sel_data = inp_1;
        case (win_idx)
            2'd1:    sel_data = inp_2;
            2'd2:    sel_data = inp_3;
            2'd3:    sel_data = inp_4;
            default: sel_data = inp_1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        out_data_d = out_data_q;
        if (accept) begin
            state_d    = HOLD;
            ptr_d      = win_idx;
            out_data_d = sel_data;
        end else begin
            case (state_q)
                HOLD:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= IDX_W'(N_REQ - 1);
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
        end
    end

    // The slot looks free while reset is asserted, so gnt is masked explicitly.
    assign gnt       = (accept && rst_n) ? idx_to_onehot(win_idx) : '0;
    assign selec_1   = win_idx[0];
    assign selec_2   = win_idx[1];
    assign out_data  = out_data_q;
    assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_rr_sched_16bit_4x1mux.sv
// Randomized and directed checks of the round-robin scheduler against a queue-free behavioural model.
module tb_rr_sched_16bit_4x1mux;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] inp [4];
    logic        out_ready;
    logic [3:0]  gnt;
    logic        selec_1, selec_2;
    logic [15:0] out_data;
    logic        out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic        exp_valid;
    logic [15:0] exp_data;
    int          ptr_m;
    int          cnt_m;
    int          exp_win;
    logic [3:0]  exp_gnt;
    logic [1:0]  exp_sel;

    rr_sched_16bit_4x1mux #(.DATA_W(16), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .inp_1     (inp[0]),
        .inp_2     (inp[1]),
        .inp_3     (inp[2]),
        .inp_4     (inp[3]),
        .gnt       (gnt),
        .selec_1   (selec_1),
        .selec_2   (selec_2),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_valid = 1'b0;
        exp_data  = '0;
        ptr_m     = 3;
        cnt_m     = 0;
    endtask

    task automatic model_eval();
        exp_win = -1;
`ifdef ARB_BURST_EN
        if (cnt_m != 0 && req[ptr_m]) exp_win = ptr_m;
`endif
        for (int k = 1; k <= 4; k++) begin
            if (exp_win < 0 && req[(ptr_m + k) % 4]) exp_win = (ptr_m + k) % 4;
        end
        exp_sel = (exp_win < 0) ? 2'b00 : 2'(exp_win);
        exp_gnt = ((!exp_valid || out_ready) && exp_win >= 0) ? 4'(1 << exp_win) : 4'b0000;
    endtask

    task automatic model_commit();
        if (exp_gnt != 4'b0000) begin
            exp_data  = inp[exp_win];
            exp_valid = 1'b1;
`ifdef ARB_BURST_EN
            cnt_m = (exp_win == ptr_m && cnt_m != 0) ? cnt_m + 1 : 1;
            if (cnt_m == MAXB) cnt_m = 0;
`endif
            ptr_m = exp_win;
        end else if (exp_valid && out_ready) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'hF;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) inp[i] = 16'($urandom);
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got=%b want=0000", gnt); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 16'h0000) $display("FAIL reset_data got=%h want=0000", out_data); else n_pass++;
        n_checks++; if ({selec_2, selec_1} !== 2'b00) $display("FAIL reset_sel got=%b want=00", {selec_2, selec_1}); else n_pass++;
        @(negedge clk);
        req   = 4'h0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        @(negedge clk);
        req    = 4'b0100;
        inp[2] = 16'hBEEF;
        out_ready = 1'b1;
        #1; model_eval();
        n_checks++; if (gnt !== 4'b0100) $display("FAIL single_gnt got=%b want=0100", gnt); else n_pass++;
        n_checks++; if ({selec_2, selec_1} !== 2'b10) $display("FAIL single_sel got=%b want=10", {selec_2, selec_1}); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_lat got=%b want=0", out_valid); else n_pass++;
        model_commit();
        @(negedge clk);
        req = 4'b0000;
        #1; model_eval();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b want=1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 16'hBEEF) $display("FAIL single_data got=%h want=beef", out_data); else n_pass++;
        n_checks++; if (gnt !== 4'b0000) $display("FAIL single_idle_gnt got=%b want=0000", gnt); else n_pass++;
        model_commit();
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_drain got=%b want=0", out_valid); else n_pass++;
    endtask

    task automatic test_fairness();
        int e, prev;
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        prev = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req       = 4'hF;
            out_ready = 1'b1;
            for (int r = 0; r < 4; r++) inp[r] = 16'(16'h1111 * (r + 1));
            #1; model_eval();
`ifdef ARB_BURST_EN
            e = (i / MAXB) % 4;
`else
            e = i % 4;
`endif
            n_checks++; if (gnt !== 4'(1 << e)) $display("FAIL fair_gnt beat=%0d got=%b want=%b", i, gnt, 4'(1 << e)); else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (out_data !== 16'(16'h1111 * (prev + 1))) $display("FAIL fair_data beat=%0d got=%h want=%h", i, out_data, 16'(16'h1111 * (prev + 1)));
                else n_pass++;
            end
            prev = e;
            model_commit();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] frozen;
        frozen = exp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req       = 4'hF;
            out_ready = 1'b0;
            #1; model_eval();
            n_checks++; if (gnt !== 4'b0000) $display("FAIL bp_gnt cyc=%0d got=%b want=0000", i, gnt); else n_pass++;
            n_checks++; if (out_data !== frozen || out_valid !== 1'b1) $display("FAIL bp_hold cyc=%0d got=%h/%b want=%h/1", i, out_data, out_valid, frozen); else n_pass++;
            model_commit();
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1; model_eval();
        n_checks++; if (gnt !== exp_gnt || exp_gnt == 4'b0000) $display("FAIL bp_release got=%b want=%b", gnt, exp_gnt); else n_pass++;
        model_commit();
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        req       = 4'hF;
        out_ready = 1'b0;
        #1; model_eval();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL midrst_pre got=%b want=1", out_valid); else n_pass++;
        model_commit();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0000) $display("FAIL midrst_async got=%b/%h want=0/0000", out_valid, out_data); else n_pass++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        model_reset();
        #1; model_eval();
        n_checks++; if (gnt !== 4'b0001) $display("FAIL midrst_first got=%b want=0001", gnt); else n_pass++;
        model_commit();
    endtask

    task automatic test_random();
        int granted;
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'h0;
        #2 rst_n = 1'b1;
        model_reset();
        granted = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (granted >= 0) req[granted] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (i == granted) continue;
                if (!req[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        inp[i] = 16'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1; model_eval();
            n_checks++; if (gnt !== exp_gnt) $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", cyc, gnt, exp_gnt); else n_pass++;
            n_checks++; if ({selec_2, selec_1} !== exp_sel) $display("FAIL rnd_sel cyc=%0d got=%b want=%b", cyc, {selec_2, selec_1}, exp_sel); else n_pass++;
            n_checks++; if (out_valid !== exp_valid) $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_checks++; if (out_data !== exp_data) $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, out_data, exp_data); else n_pass++;
            end
            granted = (exp_gnt != 4'b0000) ? exp_win : -1;
            model_commit();
        end
    endtask

`ifdef ARB_BURST_EN
    task automatic test_burst();
        int seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'h0;
        #2 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req       = 4'b0011;
            out_ready = 1'b1;
            #1; model_eval();
            n_checks++; if (gnt !== 4'(1 << seq[i])) $display("FAIL burst_gnt beat=%0d got=%b want=%b", i, gnt, 4'(1 << seq[i])); else n_pass++;
            model_commit();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid_hold();
        test_random();
`ifdef ARB_BURST_EN
        test_burst();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
